// File: rtl/des_output_serializer_if.sv
// Byte-wide valid/ready link from the DES output serializer to the USB TX path.
interface des_output_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/des_output_serializer.sv
// Captures a DES result block on data_out_i and streams it MSB byte first over tx.
// Optional macro DES_OUT_STATS_EN adds blk_count_o, a wrapping count of blocks fully sent.
module des_output_serializer #(
  parameter int BLOCK_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_out_i,
  input  logic [BLOCK_W-1:0]        des_result_i,
  des_output_serializer_if.master   tx,
  output logic                      empty_o
`ifdef DES_OUT_STATS_EN
  ,
  output logic [15:0]               blk_count_o
`endif
);
  localparam int NUM_BYTES = BLOCK_W / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [BLOCK_W-1:0] shreg_q;
  logic [BLOCK_W-1:0] shreg_shift_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               tx_valid_q;
  logic               tx_last_q;
  logic               empty_q;
`ifdef DES_OUT_STATS_EN
  logic [15:0]        blk_count_q;
`endif

  // The byte on the link is always the top byte of the shift register, so tx_data is a pure register output.
  assign shreg_shift_d = shreg_q << 4'd8;
  assign tx.tx_data    = shreg_q[BLOCK_W-1 -: 8];
  assign tx.tx_valid   = tx_valid_q;
  assign tx.tx_last    = tx_last_q;
  assign empty_o       = empty_q;
`ifdef DES_OUT_STATS_EN
  assign blk_count_o   = blk_count_q;
`endif

  // Serializer FSM with all link and controller-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= {BLOCK_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      empty_q     <= 1'b1;
`ifdef DES_OUT_STATS_EN
      blk_count_q <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (data_out_i) begin
            shreg_q    <= des_result_i;
            cnt_q      <= {CNT_W{1'b0}};
            tx_valid_q <= 1'b1;
            tx_last_q  <= (NUM_BYTES == 1);
            empty_q    <= 1'b0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_q && tx.tx_ready) begin
            // The final shift also clears the register, so tx_data idles at zero.
            shreg_q <= shreg_shift_d;
            if (cnt_q == LAST_CNT) begin
              tx_valid_q  <= 1'b0;
              tx_last_q   <= 1'b0;
              empty_q     <= 1'b1;
              state_q     <= DONE;
`ifdef DES_OUT_STATS_EN
              blk_count_q <= blk_count_q + 16'd1;
`endif
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
              tx_last_q <= ((cnt_q + CNT_ONE) == LAST_CNT);
            end
          end
        end
        DONE: begin
          // Hold off until the controller drops data_out so the same block is not recaptured.
          if (!data_out_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
          empty_q    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_des_output_serializer.sv
// Directed self-checking bench for des_output_serializer; stats checks run when DES_OUT_STATS_EN is defined.
module tb_des_output_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_out;
  logic [63:0] des_result;
  logic        empty;
`ifdef DES_OUT_STATS_EN
  logic [15:0] blk_count;
`endif

  int checks = 0;
  int errors = 0;
  int c2, c3, c4, c5;

  localparam logic [63:0] BLK_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BLK_B = 64'hFFFF_0000_AAAA_5555;

  des_output_serializer_if txif ();

  des_output_serializer #(.BLOCK_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_out_i   (data_out),
    .des_result_i (des_result),
    .tx           (txif.master),
    .empty_o      (empty)
`ifdef DES_OUT_STATS_EN
    ,
    .blk_count_o  (blk_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a block with data_out high for the capture edge; optionally keep data_out high afterwards.
  task automatic start_block(input logic [63:0] blk, input bit keep);
    des_result = blk;
    data_out   = 1'b1;
    tick();
    if (!keep) data_out = 1'b0;
    des_result = ~blk;
  endtask

  // Walk the eight bytes from the cycle after capture, optionally stalling before byte stall_idx.
  task automatic drain(input logic [63:0] blk, input int stall_idx, input int stall_n,
                       input string tag, output int cycles);
    logic [7:0] exp_b;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      exp_b = blk[63 - 8*i -: 8];
      if (i == stall_idx) begin
        txif.tx_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk($sformatf("%s stall%0d data", tag, s), {56'd0, txif.tx_data}, {56'd0, exp_b});
          chk($sformatf("%s stall%0d valid", tag, s), {63'd0, txif.tx_valid}, 64'd1);
          tick();
          cycles++;
        end
        txif.tx_ready = 1'b1;
      end
      chk($sformatf("%s byte%0d data", tag, i), {56'd0, txif.tx_data}, {56'd0, exp_b});
      chk($sformatf("%s byte%0d valid", tag, i), {63'd0, txif.tx_valid}, 64'd1);
      chk($sformatf("%s byte%0d last", tag, i), {63'd0, txif.tx_last}, (i == 7) ? 64'd1 : 64'd0);
      chk($sformatf("%s byte%0d empty", tag, i), {63'd0, empty}, 64'd0);
      tick();
      cycles++;
    end
    chk({tag, " end valid"}, {63'd0, txif.tx_valid}, 64'd0);
    chk({tag, " end empty"}, {63'd0, empty}, 64'd1);
  endtask

  initial begin
    rst           = 1'b1;
    data_out      = 1'b0;
    des_result    = 64'd0;
    txif.tx_ready = 1'b1;

    // Test 1: reset state
    tick();
    tick();
    chk("rst empty", {63'd0, empty}, 64'd1);
    chk("rst valid", {63'd0, txif.tx_valid}, 64'd0);
    chk("rst data", {56'd0, txif.tx_data}, 64'd0);
    chk("rst last", {63'd0, txif.tx_last}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle valid", {63'd0, txif.tx_valid}, 64'd0);

    // Test 2: full-rate block, des_result changed after capture
    start_block(BLK_A, 1'b0);
    chk("t2 first byte", {56'd0, txif.tx_data}, 64'h01);
    drain(BLK_A, -1, 0, "t2", c2);
    chk("t2 cycles", c2, 64'd8);
    tick();

    // Test 3: three stall cycles on byte 0x45
    start_block(BLK_A, 1'b0);
    drain(BLK_A, 2, 3, "t3", c3);
    chk("t3 stretch", c3 - c2, 64'd3);
    tick();

    // Test 4: data_out held high after DONE must not recapture
    start_block(BLK_A, 1'b1);
    drain(BLK_A, -1, 0, "t4a", c4);
    chk("t4a cycles", c4, 64'd8);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t4 hold%0d valid", k), {63'd0, txif.tx_valid}, 64'd0);
      chk($sformatf("t4 hold%0d empty", k), {63'd0, empty}, 64'd1);
    end
    data_out = 1'b0;
    tick();
    start_block(BLK_B, 1'b0);
    chk("t4b first byte", {56'd0, txif.tx_data}, 64'hFF);
    drain(BLK_B, -1, 0, "t4b", c4);
    tick();

    // Test 5: reset mid-block after three handshakes
    start_block(BLK_A, 1'b0);
    tick();
    tick();
    tick();
    chk("t5 pre-rst data", {56'd0, txif.tx_data}, 64'h67);
    rst = 1'b1;
    tick();
    chk("t5 rst valid", {63'd0, txif.tx_valid}, 64'd0);
    chk("t5 rst empty", {63'd0, empty}, 64'd1);
    chk("t5 rst data", {56'd0, txif.tx_data}, 64'd0);
    chk("t5 rst last", {63'd0, txif.tx_last}, 64'd0);
    rst = 1'b0;
    tick();
    start_block(BLK_B, 1'b0);
    drain(BLK_B, -1, 0, "t5", c5);
    tick();

`ifdef DES_OUT_STATS_EN
    // Test 6: block counter, including wrap from 16'hFFFF
    chk("t6 count after rst", {48'd0, blk_count}, 64'd1);
    start_block(BLK_A, 1'b0);
    drain(BLK_A, -1, 0, "t6a", c5);
    tick();
    start_block(BLK_B, 1'b0);
    drain(BLK_B, -1, 0, "t6b", c5);
    tick();
    chk("t6 count 3", {48'd0, blk_count}, 64'd3);
    force dut.blk_count_q = 16'hFFFF;
    #1;
    release dut.blk_count_q;
    chk("t6 preload", {48'd0, blk_count}, 64'hFFFF);
    start_block(BLK_A, 1'b0);
    drain(BLK_A, -1, 0, "t6c", c5);
    chk("t6 wrap", {48'd0, blk_count}, 64'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
